// File: rtl/multicycle_ctrl_seq.sv
// multicycle_ctrl_seq
//   Multi-cycle control and PC sequencer for an RV64I subset
//   (add, sub, and, or, ld, sd, beq). Owns the architectural PC and a
//   retired-instruction counter. It steps FETCH -> DECODE -> EX [-> MEM] [-> WB]
//   and drives the datapath control lines as registered Moore outputs.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset, overrides everything
//   run       in   permits a new fetch; sampled only in FETCH
//   instr     in   instruction word at pc, latched into IR in FETCH
//   pc_next   in   datapath next-PC, sampled on an instruction's final cycle
//   pc        out  architectural PC
//   RegWrite, ALUSrc, ALUop, MemWrite, MemRead, MemtoReg  out  datapath controls
//   halted    out  high while in HALT
//   err_code  out  halt cause: 00 none, 01 illegal instruction, 10 misaligned pc_next
//   retired   out  completed-instruction count, wraps modulo 2^CNT_W
module multicycle_ctrl_seq #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic [63:0]      pc_next,
  output logic [63:0]      pc,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [3:0]       ALUop,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             MemtoReg,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EX     = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ADD = 3'd0,
    C_SUB = 3'd1,
    C_AND = 3'd2,
    C_OR  = 3'd3,
    C_LD  = 3'd4,
    C_SD  = 3'd5,
    C_BEQ = 3'd6,
    C_ILL = 3'd7
  } cls_t;

  // Classify an instruction word from opcode, funct3 and funct7.
  function automatic cls_t classify(input logic [31:0] ir);
    cls_t c;
    c = C_ILL;
    case (ir[6:0])
      7'b0110011: begin
        case ({ir[31:25], ir[14:12]})
          10'b0000000_000: c = C_ADD;
          10'b0100000_000: c = C_SUB;
          10'b0000000_111: c = C_AND;
          10'b0000000_110: c = C_OR;
          default:         c = C_ILL;
        endcase
      end
      7'b0000011: c = (ir[14:12] == 3'b011) ? C_LD  : C_ILL;
      7'b0100011: c = (ir[14:12] == 3'b011) ? C_SD  : C_ILL;
      7'b1100011: c = (ir[14:12] == 3'b000) ? C_BEQ : C_ILL;
      default:    c = C_ILL;
    endcase
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [63:0]      pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [1:0]       err_q, err_d;
  logic             halted_q, halted_d;
  logic             reg_write_q, reg_write_d;
  logic             alu_src_q, alu_src_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             final_s;
  cls_t             cls_s;
  logic             ir_unused_s;

  // Register fields (rd/rs/imm) are the datapath's business, not the sequencer's.
  assign ir_unused_s = ^{ir_q[24:15], ir_q[11:7]};

  // IR is stable from DECODE to the end of the instruction, so the class
  // can be derived from it directly instead of being latched separately.
  assign cls_s = classify(ir_q);

  // Next-state, IR, PC, retire counter and halt cause.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    err_d     = err_q;
    final_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (cls_s == C_ILL) begin
          state_d = S_HALT;
          err_d   = 2'b01;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (cls_s)
          C_BEQ:                      final_s = 1'b1;
          C_LD, C_SD:                 state_d = S_MEM;
          C_ADD, C_SUB, C_AND, C_OR:  state_d = S_WB;
          default: begin
            state_d = S_HALT;
            err_d   = 2'b01;
          end
        endcase
      end
      S_MEM: begin
        if (cls_s == C_LD) begin
          state_d = S_WB;
        end else begin
          final_s = 1'b1;
        end
      end
      S_WB:    final_s = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Retirement: a misaligned target halts without touching pc or the count.
    if (final_s) begin
      if (pc_next[1:0] == 2'b00) begin
        pc_d      = pc_next;
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d   = S_FETCH;
      end else begin
        state_d = S_HALT;
        err_d   = 2'b10;
      end
    end else begin
      final_s = 1'b0;
    end
  end

  // Controls are decoded from the state being entered so the registered
  // outputs line up with the cycle spent in that state.
  always_comb begin
    reg_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    alu_op_d     = 4'b0000;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_to_reg_d = 1'b0;
    halted_d     = (state_d == S_HALT);
    if (state_d == S_EX || state_d == S_MEM || state_d == S_WB) begin
      alu_src_d = (cls_s == C_LD) || (cls_s == C_SD);
      case (cls_s)
        C_ADD, C_LD, C_SD: alu_op_d = 4'b0010;
        C_SUB, C_BEQ:      alu_op_d = 4'b0110;
        C_AND:             alu_op_d = 4'b0000;
        C_OR:              alu_op_d = 4'b0001;
        default:           alu_op_d = 4'b0000;
      endcase
    end else begin
      alu_src_d = 1'b0;
    end
    case (state_d)
      S_MEM: begin
        mem_read_d  = (cls_s == C_LD);
        mem_write_d = (cls_s == C_SD);
      end
      S_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = (cls_s == C_LD);
      end
      default: begin
        reg_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      ir_q         <= 32'd0;
      pc_q         <= RESET_PC;
      retired_q    <= '0;
      err_q        <= 2'b00;
      halted_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= 4'b0000;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      pc_q         <= pc_d;
      retired_q    <= retired_d;
      err_q        <= err_d;
      halted_q     <= halted_d;
      reg_write_q  <= reg_write_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign pc       = pc_q;
  assign retired  = retired_q;
  assign err_code = err_q;
  assign halted   = halted_q;
  assign RegWrite = reg_write_q;
  assign ALUSrc   = alu_src_q;
  assign ALUop    = alu_op_q;
  assign MemWrite = mem_write_q;
  assign MemRead  = mem_read_q;
  assign MemtoReg = mem_to_reg_q;

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Testbench for multicycle_ctrl_seq: a table of directed instructions,
// hand-written halt/reset corner cases, then randomized instruction streams
// checked against an instruction-level reference model.
module tb_multicycle_ctrl_seq;

  localparam logic [63:0] RPC = 64'd8;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [31:0] instr;
  logic [63:0] pc_next;
  logic [63:0] pc;
  logic        RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, halted;
  logic [3:0]  ALUop;
  logic [1:0]  err_code;
  logic [31:0] retired;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // reference model state
  logic [63:0] m_pc;
  logic [31:0] m_ret;
  logic        m_halt;
  logic [1:0]  m_err;

  multicycle_ctrl_seq #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .pc_next(pc_next),
    .pc(pc), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUop(ALUop),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .halted(halted), .err_code(err_code), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pn;
    int          len;
    logic [1:0]  err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ctrl_vec();
    return {RegWrite, ALUSrc, ALUop, MemWrite, MemRead, MemtoReg};
  endfunction

  // 0 add, 1 sub, 2 and, 3 or, 4 ld, 5 sd, 6 beq, 7 illegal
  function automatic int kind_of(input logic [31:0] w);
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000) return 0;
    if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) return 1;
    if (op == 7'b0110011 && f3 == 3'b111 && f7 == 7'b0000000) return 2;
    if (op == 7'b0110011 && f3 == 3'b110 && f7 == 7'b0000000) return 3;
    if (op == 7'b0000011 && f3 == 3'b011) return 4;
    if (op == 7'b0100011 && f3 == 3'b011) return 5;
    if (op == 7'b1100011 && f3 == 3'b000) return 6;
    return 7;
  endfunction

  function automatic int len_of(input int k);
    case (k)
      4:       return 5;
      5:       return 4;
      6:       return 3;
      7:       return 2;
      default: return 4;
    endcase
  endfunction

  // Expected controls during the p-th cycle of an instruction (0 = fetch).
  function automatic logic [8:0] exp_ctrl(input int k, input int p);
    logic [3:0] alu; logic src, is_mem, is_wb;
    if (p < 2 || k == 7) return 9'd0;
    case (k)
      0, 4, 5: alu = 4'b0010;
      1, 6:    alu = 4'b0110;
      2:       alu = 4'b0000;
      default: alu = 4'b0001;
    endcase
    src    = (k == 4 || k == 5);
    is_mem = (p == 3) && src;
    is_wb  = (p == 4) || (p == 3 && k <= 3);
    return {is_wb, src, alu, is_mem && k == 5, is_mem && k == 4, is_wb && k == 4};
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_retired"}, {32'd0, retired}, {32'd0, m_ret});
    chk({tag, "_halted"}, {63'd0, halted}, {63'd0, m_halt});
    chk({tag, "_err"}, {62'd0, err_code}, {62'd0, m_err});
    chk({tag, "_ctrl"}, {55'd0, ctrl_vec()}, 64'd0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    run = 1'($urandom_range(0, 1));
    for (int i = 0; i < cycles; i++) step();
    reset = 1'b0;
    run = 1'b0;
    m_pc = RPC; m_ret = 32'd0; m_halt = 1'b0; m_err = 2'b00;
    check_state("reset");
  endtask

  // Drive one instruction through all its cycles; pc_next and instr are
  // scrambled on cycles where the sequencer must ignore them.
  task automatic run_instr(input logic [31:0] ins, input logic [63:0] pn, input int len);
    int k;
    logic [63:0] pc0;
    k = kind_of(ins);
    pc0 = m_pc;
    for (int s = 1; s <= len; s++) begin
      if (s == 1) begin
        run = 1'b1;
        instr = ins;
      end else begin
        run = 1'($urandom_range(0, 1));
        instr = $urandom;
      end
      pc_next = (s == len) ? pn : {$urandom, $urandom};
      step();
      if (s < len) begin
        chk("phase_ctrl", {55'd0, ctrl_vec()}, {55'd0, exp_ctrl(k, s)});
        chk("phase_pc", pc, pc0);
        chk("phase_halted", {63'd0, halted}, 64'd0);
      end
    end
    if (k == 7) begin
      m_halt = 1'b1; m_err = 2'b01;
    end else if (pn[1:0] != 2'b00) begin
      m_halt = 1'b1; m_err = 2'b10;
    end else begin
      m_pc = pn; m_ret = m_ret + 32'd1;
    end
    check_state("retire");
    run = 1'b0;
  endtask

  task automatic halt_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      run = 1'($urandom_range(0, 1));
      instr = $urandom;
      pc_next = {$urandom, $urandom} & ~64'd3;
      step();
      check_state("halt_hold");
    end
    run = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr(input int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      0: return {7'b0000000, r[24:15], 3'b000, r[11:7], 7'b0110011};
      1: return {7'b0100000, r[24:15], 3'b000, r[11:7], 7'b0110011};
      2: return {7'b0000000, r[24:15], 3'b111, r[11:7], 7'b0110011};
      3: return {7'b0000000, r[24:15], 3'b110, r[11:7], 7'b0110011};
      4: return {r[31:15], 3'b011, r[11:7], 7'b0000011};
      5: return {r[31:15], 3'b011, r[11:7], 7'b0100011};
      6: return {r[31:15], 3'b000, r[11:7], 7'b1100011};
      default: return r;
    endcase
  endfunction

  vec_t tbl[7];

  initial begin
    reset = 1'b0; run = 1'b0; instr = 32'd0; pc_next = 64'd0;

    tbl[0] = '{32'h002081B3, 64'd12,   4, 2'b00}; // add
    tbl[1] = '{32'h0000B103, 64'd16,   5, 2'b00}; // ld
    tbl[2] = '{32'h0020B023, 64'd20,   4, 2'b00}; // sd
    tbl[3] = '{32'h00208463, 64'h18,   3, 2'b00}; // beq
    tbl[4] = '{32'h402081B3, 64'h1C,   4, 2'b00}; // sub
    tbl[5] = '{32'h0020F1B3, 64'h20,   4, 2'b00}; // and
    tbl[6] = '{32'h0020E1B3, 64'h100,  4, 2'b00}; // or

    // reset, then idle with run low
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      instr = $urandom; pc_next = {$urandom, $urandom};
      step();
      check_state("idle");
    end

    // directed table
    for (int i = 0; i < 7; i++) begin
      run_instr(tbl[i].ins, tbl[i].pn, tbl[i].len);
      chk("tbl_err", {62'd0, err_code}, {62'd0, tbl[i].err});
    end
    chk("tbl_retired", {32'd0, retired}, 64'd7);
    chk("tbl_pc", pc, 64'h100);

    // illegal instruction halts after DECODE; run has no effect afterwards
    run_instr(32'hFFFFFFFF, 64'd0, 2);
    chk("illegal_err", {62'd0, err_code}, 64'd1);
    halt_hold(6);

    // misaligned pc_next
    do_reset(2);
    run_instr(32'h002081B3, 64'd12, 4);
    run_instr(32'h002081B3, 64'h0E, 4);
    chk("misalign_err", {62'd0, err_code}, 64'd2);
    chk("misalign_retired", {32'd0, retired}, 64'd1);
    halt_hold(4);

    // reset during MEM of sd
    do_reset(1);
    run_instr(32'h002081B3, 64'd12, 4);
    run = 1'b1; instr = 32'h0020B023; pc_next = 64'd16;
    for (int s = 1; s <= 3; s++) begin
      step();
      run = 1'b0;
    end
    chk("sd_mem_write", {63'd0, MemWrite}, 64'd1);
    do_reset(1);
    step();
    check_state("post_reset_idle");
    run_instr(32'h002081B3, 64'd12, 4);

    // randomized stream
    do_reset(1);
    for (int n = 0; n < 150; n++) begin
      int k;
      logic [31:0] w;
      logic [63:0] pn;
      if (m_halt) begin
        halt_hold(2);
        do_reset(1);
      end
      if ($urandom_range(0, 3) == 0) begin
        int idle;
        idle = $urandom_range(1, 3);
        for (int i = 0; i < idle; i++) begin
          instr = $urandom;
          step();
          check_state("rand_idle");
        end
      end
      k = ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, 6));
      w = rand_instr(k);
      if ($urandom_range(0, 11) == 0) begin
        pn = {$urandom, $urandom};
        if (pn[1:0] == 2'b00) pn[0] = 1'b1;
      end else if ($urandom_range(0, 1) == 0) begin
        pn = m_pc + 64'd4;
      end else begin
        pn = {$urandom, $urandom} & ~64'd3;
      end
      run_instr(w, pn, len_of(kind_of(w)));
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
